// File: rtl/if_stage.sv
// if_stage: TinyCPU instruction-fetch stage.
//
// Owns the program counter. It issues one instruction-memory request at a time
// over a req/gnt/rvalid handshake. It then holds the fetched {pc, inst} pair,
// with a completion flag, for the IF/ID register until ID accepts it or a
// jump/branch redirect drops it.
//
// Parameters:
//   RegW      PC / address / instruction width (default 32)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk_i              clock, all state on posedge
//   rst_ni             synchronous active-low reset
//   ctl_id_allow_in_i  ID accepts the held instruction this cycle
//   ctl_jbr_taken_i    redirect request, highest priority
//   jbr_target_i       redirect target PC
//   inst_req_o         memory request
//   inst_addr_o        request address (current PC)
//   inst_gnt_i         memory accepted the request
//   inst_rvalid_i      response valid
//   inst_rdata_i       response instruction
//   if_pc_o            PC of the held instruction
//   if_inst_o          held instruction
//   ctl_if_over_o      held instruction valid (S_DONE)
//   if_misalign_o      only with IF_MISALIGN_CHK_EN: the held instruction is a
//                      NOP substituted for a misaligned fetch
//
// Optional feature macro: IF_MISALIGN_CHK_EN
module if_stage #(
  parameter int              RegW     = 32,
  parameter logic [RegW-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ctl_id_allow_in_i,
  input  logic            ctl_jbr_taken_i,
  input  logic [RegW-1:0] jbr_target_i,
  output logic            inst_req_o,
  output logic [RegW-1:0] inst_addr_o,
  input  logic            inst_gnt_i,
  input  logic            inst_rvalid_i,
  input  logic [RegW-1:0] inst_rdata_i,
  output logic [RegW-1:0] if_pc_o,
  output logic [RegW-1:0] if_inst_o,
  output logic            ctl_if_over_o
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic            if_misalign_o
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [RegW-1:0] pc_q, pc_d;
  logic [RegW-1:0] inst_q, inst_d;
  logic [RegW-1:0] ifpc_q, ifpc_d;
  logic            kill_q, kill_d;
  logic            pc_misaligned;

`ifdef IF_MISALIGN_CHK_EN
  localparam logic [RegW-1:0] NopInst = RegW'(32'h0000_0013);
  logic mis_q, mis_d;
  assign pc_misaligned = (pc_q[1:0] != 2'b00);
  assign if_misalign_o = mis_q;
`else
  assign pc_misaligned = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      inst_q  <= '0;
      ifpc_q  <= '0;
`ifdef IF_MISALIGN_CHK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
`ifdef IF_MISALIGN_CHK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    inst_d     = inst_q;
    ifpc_d     = ifpc_q;
`ifdef IF_MISALIGN_CHK_EN
    mis_d      = mis_q;
`endif
    inst_req_o = 1'b0;
    unique case (state_q)
      S_REQ: begin
        // Request is masked during reset so memory never sees a stray fetch.
        inst_req_o = rst_ni && !ctl_jbr_taken_i && !pc_misaligned;
        if (ctl_jbr_taken_i) begin
          pc_d = jbr_target_i;
`ifdef IF_MISALIGN_CHK_EN
        end else if (pc_misaligned) begin
          // No memory access; hand ID a NOP flagged as misaligned.
          inst_d  = NopInst;
          ifpc_d  = pc_q;
          mis_d   = 1'b1;
          state_d = S_DONE;
`endif
        end else if (inst_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ctl_jbr_taken_i) pc_d = jbr_target_i;
        if (inst_rvalid_i) begin
          // A redirect seen now or earlier makes this response stale.
          if (kill_q || ctl_jbr_taken_i) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = inst_rdata_i;
            ifpc_d  = pc_q;
            state_d = S_DONE;
          end
        end else if (ctl_jbr_taken_i) begin
          kill_d = 1'b1;
        end
      end
      S_DONE: begin
        // Redirect beats allow_in: if_id drops the slot on a redirect.
        if (ctl_jbr_taken_i) begin
          pc_d    = jbr_target_i;
          state_d = S_REQ;
`ifdef IF_MISALIGN_CHK_EN
          mis_d   = 1'b0;
`endif
        end else if (ctl_id_allow_in_i) begin
          pc_d    = pc_q + RegW'(4);
          state_d = S_REQ;
`ifdef IF_MISALIGN_CHK_EN
          mis_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign inst_addr_o   = pc_q;
  assign if_pc_o       = ifpc_q;
  assign if_inst_o     = inst_q;
  assign ctl_if_over_o = (state_q == S_DONE);

endmodule
